alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single ArithmeticLogicUnit between two requesters, e.g. the execute stage (port 0) and the debug/microcode port (port 1).
- Arbitrates between the requesters, registers the granted operation and operands, and drives the ALU for one cycle.
- Captures OutDest/OutFlags and returns them through a valid/ready response handshake.
- Sits between the requesters and the ALU instance; uses eOperation, sFlags, DataWidth and ImmediateWidth from InstructionSetPkg.

Parameters:
NumReq, 2, number of requesters (fixed at 2; the round-robin pointer is 1 bit).
DataWidth, InstructionSetPkg::DataWidth (16), operand/result width.
ImmediateWidth, InstructionSetPkg::ImmediateWidth (6), immediate width.

Ports:
Clock  in  1  system clock, rising edge.
nReset  in  1  asynchronous active-low reset.
ReqValid  in  2  per-requester request valid.
ReqReady  out  2  per-requester accept (one-hot or zero).
ReqOp  in  2 x eOperation  requested ALU operation.
ReqSrc  in  2 x DataWidth  source operand.
ReqDest  in  2 x DataWidth  destination operand.
ReqImm  in  2 x ImmediateWidth  immediate.
ReqFlags  in  2 x sFlags  input flags (carry used by ADC/SUB/ROL/ROR).
RspValid  out  2  per-requester response valid (one-hot or zero).
RspReady  in  2  per-requester response accept.
RspData  out  DataWidth  captured OutDest.
RspFlags  out  sFlags  captured OutFlags.
AluOperation  out  eOperation  to ALU Operation.
AluSrc  out  DataWidth  to ALU InSrc.
AluDest  out  DataWidth  to ALU InDest.
AluImm  out  ImmediateWidth  to ALU InImm.
AluFlags  out  sFlags  to ALU InFlags.
AluOutDest  in  DataWidth  from ALU OutDest.
AluOutFlags  in  sFlags  from ALU OutFlags.
Busy  out  1  high whenever state != IDLE.
GrantId  out  1  index of the current/last granted requester.

Behaviour:
- States: IDLE, EXEC, RESP (one-hot or binary, designer's choice).
- Reset (nReset low, async): state=IDLE; RR pointer=0; GrantId=0; all operand registers 0; AluOperation=MOVE; RspData=0; RspFlags=sFlags'(0); all ReqReady/RspValid=0; Busy=0.
  - Reset mid-EXEC or mid-RESP drops the transaction silently; no response is ever issued for it.
- IDLE:
  - ReqReady[g] is combinational: high only for the winner g when ReqValid[g]=1.
  - Winner selection: if only one ReqValid is high, that requester wins; if both are high, requester RR pointer wins.
  - At the accept edge k: latch ReqOp/Src/Dest/Imm/Flags[g] into registers, GrantId<=g, go to EXEC.
  - No request pending: stay in IDLE; ALU outputs hold their last values.
- EXEC:
  - ALU inputs are driven only from the registered operands (no combinational path from Req* to Alu*).
  - At edge k+1: RspData<=AluOutDest, RspFlags<=AluOutFlags, go to RESP.
- RESP:
  - RspValid[GrantId]=1 from edge k+1; RspData/RspFlags stay stable until the handshake.
  - On RspValid&RspReady[GrantId] at an edge: go to IDLE, RR pointer<=~GrantId.
  - RspReady of the non-granted requester is ignored.
  - No new request is accepted in EXEC or RESP; ReqReady=0 there.
- Latency: accept edge k -> response visible after edge k+1. Minimum issue interval is 3 cycles (IDLE, EXEC, RESP).
- Requester rule: ReqValid and payload stay stable until ReqReady. The arbiter samples the payload only at the accept edge.
- Fairness: under continuous contention, grants alternate 0,1,0,1...
- A requester that drops ReqValid before being granted loses nothing; the pointer updates only on completion.
- Flags are passed through verbatim; the arbiter does no arithmetic.

Optional Feature:
ALU_ARB_FIXED_PRIORITY_EN
- Defined: requester 0 always wins contention; the RR pointer is removed and GrantId still reports the winner.
- Undefined (default): round-robin as in Behaviour.

Test Plan:
1. Reset, then req0 ADC Dest=0x7FFF Src=0x0001 Carry=0, RspReady0=1 -> ReqReady0 at accept edge k; RspValid0 after edge k+1; RspData=0x8000, RspFlags=sFlags'(20); back to IDLE one cycle later.
2. Both ReqValid high continuously, req0 MOVE Src=0x1111, req1 MOVE Src=0x2222 -> grants 0,1,0,1 with GrantId matching; RspData alternates 0x1111/0x2222; RspValid never on the wrong port. With ALU_ARB_FIXED_PRIORITY_EN, always 0x1111.
3. req1 NAND Dest=0x9999 Src=0xA5A5, RspReady1 held low 5 cycles -> RspValid1 and RspData=0x7E7E stable all 5 cycles; ReqValid0 raised meanwhile sees ReqReady0=0 until the cycle after the response handshake.
4. Accept req0 ADC, pulse nReset low mid-EXEC -> all outputs at reset values immediately; no RspValid after release; a new req1 is then served normally.
5. req0 SUB Dest=0x0000 Src=0x00A4 Carry=1 while req1 changes its payload in the same cycles -> response 0xFF5B; the ALU sees only the latched req0 operands (AluSrc stable through EXEC).
6. ReqValid toggled in EXEC/RESP -> ReqReady stays 0; Busy=1 throughout EXEC/RESP; Busy=0 in IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared ArithmeticLogicUnit: grant, register operands, run one ALU cycle, return the result.
// Build option: define ALU_ARB_FIXED_PRIORITY_EN to make requester 0 win every contention (round-robin otherwise).

package InstructionSetPkg;

    parameter int DataWidth      = 16;
    parameter int ImmediateWidth = 6;

    typedef enum logic [3:0] {
        MOVE, ADD, ADC, SUB, AND, OR, XOR, NAND, ROL, ROR, SHL, SHR
    } eOperation;

    typedef struct packed {
        logic Overflow;
        logic Parity;
        logic Negative;
        logic Zero;
        logic Carry;
    } sFlags;

endpackage

module alu_arbiter
    import InstructionSetPkg::*;
#(
    parameter int NumReq         = 2,
    parameter int DataWidth      = InstructionSetPkg::DataWidth,
    parameter int ImmediateWidth = InstructionSetPkg::ImmediateWidth
) (
    input  logic                                   Clock,
    input  logic                                   nReset,
    input  logic [NumReq-1:0]                      ReqValid,
    output logic [NumReq-1:0]                      ReqReady,
    input  eOperation [NumReq-1:0]                 ReqOp,
    input  logic [NumReq-1:0][DataWidth-1:0]       ReqSrc,
    input  logic [NumReq-1:0][DataWidth-1:0]       ReqDest,
    input  logic [NumReq-1:0][ImmediateWidth-1:0]  ReqImm,
    input  sFlags [NumReq-1:0]                     ReqFlags,
    output logic [NumReq-1:0]                      RspValid,
    input  logic [NumReq-1:0]                      RspReady,
    output logic [DataWidth-1:0]                   RspData,
    output sFlags                                  RspFlags,
    output eOperation                              AluOperation,
    output logic [DataWidth-1:0]                   AluSrc,
    output logic [DataWidth-1:0]                   AluDest,
    output logic [ImmediateWidth-1:0]              AluImm,
    output sFlags                                  AluFlags,
    input  logic [DataWidth-1:0]                   AluOutDest,
    input  sFlags                                  AluOutFlags,
    output logic                                   Busy,
    output logic                                   GrantId
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} eState;

    eState                     state;
    eState                     nextState;
    logic                      winner;
    logic                      contendWinner;
    logic                      accept;
    logic                      complete;
    eOperation                 opReg;
    logic [DataWidth-1:0]      srcReg;
    logic [DataWidth-1:0]      destReg;
    logic [ImmediateWidth-1:0] immReg;
    sFlags                     flagsReg;

    assign accept   = (state == IDLE) && (|ReqValid);
    assign complete = (state == RESP) && RspReady[GrantId];

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    assign contendWinner = 1'b0;
`else
    logic rrPtr;

    // The pointer only moves when a transaction completes, so a requester that withdraws early keeps its turn.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rrPtr <= 1'b0;
        end else if (complete) begin
            rrPtr <= ~GrantId;
        end
    end

    assign contendWinner = rrPtr;
`endif

    always_comb begin
        winner = contendWinner;
        if (ReqValid[0] && !ReqValid[1]) begin
            winner = 1'b0;
        end else if (ReqValid[1] && !ReqValid[0]) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        ReqReady  = '0;
        RspValid  = '0;
        nextState = state;
        case (state)
            IDLE: begin
                if (|ReqValid) begin
                    ReqReady[winner] = 1'b1;
                    nextState        = EXEC;
                end
            end
            EXEC: begin
                nextState = RESP;
            end
            RESP: begin
                RspValid[GrantId] = 1'b1;
                if (RspReady[GrantId]) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Operand registers feed the ALU directly, so requester payloads never reach it combinationally.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            GrantId  <= 1'b0;
            opReg    <= MOVE;
            srcReg   <= '0;
            destReg  <= '0;
            immReg   <= '0;
            flagsReg <= '0;
            RspData  <= '0;
            RspFlags <= '0;
        end else begin
            if (accept) begin
                GrantId  <= winner;
                opReg    <= ReqOp[winner];
                srcReg   <= ReqSrc[winner];
                destReg  <= ReqDest[winner];
                immReg   <= ReqImm[winner];
                flagsReg <= ReqFlags[winner];
            end
            if (state == EXEC) begin
                RspData  <= AluOutDest;
                RspFlags <= AluOutFlags;
            end
        end
    end

    assign AluOperation = opReg;
    assign AluSrc       = srcReg;
    assign AluDest      = destReg;
    assign AluImm       = immReg;
    assign AluFlags     = flagsReg;
    assign Busy         = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter; a small ALU model answers the arbiter's ALU port.
// Honours ALU_ARB_FIXED_PRIORITY_EN when the design is built with it.

module tb_alu_arbiter;
    import InstructionSetPkg::*;

    logic             Clock = 1'b0;
    logic             nReset = 1'b0;
    logic [1:0]       ReqValid = '0;
    logic [1:0]       ReqReady;
    eOperation [1:0]  ReqOp = {MOVE, MOVE};
    logic [1:0][15:0] ReqSrc = '0;
    logic [1:0][15:0] ReqDest = '0;
    logic [1:0][5:0]  ReqImm = '0;
    sFlags [1:0]      ReqFlags = '0;
    logic [1:0]       RspValid;
    logic [1:0]       RspReady = '0;
    logic [15:0]      RspData;
    sFlags            RspFlags;
    eOperation        AluOperation;
    logic [15:0]      AluSrc;
    logic [15:0]      AluDest;
    logic [5:0]       AluImm;
    sFlags            AluFlags;
    logic [15:0]      AluOutDest;
    sFlags            AluOutFlags;
    logic             Busy;
    logic             GrantId;

    int errors = 0;
    int checks = 0;
    logic expG;

    alu_arbiter dut (
        .Clock(Clock), .nReset(nReset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqSrc(ReqSrc), .ReqDest(ReqDest), .ReqImm(ReqImm), .ReqFlags(ReqFlags),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspFlags(RspFlags),
        .AluOperation(AluOperation), .AluSrc(AluSrc), .AluDest(AluDest),
        .AluImm(AluImm), .AluFlags(AluFlags),
        .AluOutDest(AluOutDest), .AluOutFlags(AluOutFlags),
        .Busy(Busy), .GrantId(GrantId)
    );

    always #5 Clock = ~Clock;

    // Reference ALU covering the operations the directed steps use.
    always_comb begin
        logic [16:0] wide;
        wide        = {1'b0, AluDest};
        AluOutFlags = '0;
        case (AluOperation)
            MOVE:    wide = {1'b0, AluSrc};
            ADC:     wide = {1'b0, AluDest} + {1'b0, AluSrc} + 17'(AluFlags.Carry);
            SUB:     wide = {1'b0, AluDest} - {1'b0, AluSrc} - 17'(AluFlags.Carry);
            NAND:    wide = {1'b0, ~(AluDest & AluSrc)};
            default: wide = {1'b0, AluDest};
        endcase
        AluOutDest           = wide[15:0];
        AluOutFlags.Carry    = wide[16];
        AluOutFlags.Zero     = (wide[15:0] == 16'h0000);
        AluOutFlags.Negative = wide[15];
        AluOutFlags.Parity   = ~^wide[15:0];
        if (AluOperation == ADC) begin
            AluOutFlags.Overflow = (AluDest[15] == AluSrc[15]) && (wide[15] != AluDest[15]);
        end else if (AluOperation == SUB) begin
            AluOutFlags.Overflow = (AluDest[15] != AluSrc[15]) && (wide[15] != AluDest[15]);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input eOperation op, input logic [15:0] src,
                                 input logic [15:0] dest, input logic [5:0] imm, input logic carry);
        ReqOp[port]          = op;
        ReqSrc[port]         = src;
        ReqDest[port]        = dest;
        ReqImm[port]         = imm;
        ReqFlags[port]       = '0;
        ReqFlags[port].Carry = carry;
        ReqValid[port]       = 1'b1;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the directed sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("rst Busy", 32'(Busy), 32'h0);
        checkOutput("rst ReqReady", 32'(ReqReady), 32'h0);
        checkOutput("rst RspValid", 32'(RspValid), 32'h0);
        checkOutput("rst RspData", 32'(RspData), 32'h0);
        checkOutput("rst RspFlags", 32'(RspFlags), 32'h0);
        checkOutput("rst AluOperation", 32'(AluOperation), 32'(MOVE));
        checkOutput("rst GrantId", 32'(GrantId), 32'h0);
        nReset = 1'b1;
        tick();

        // Single ADC from requester 0
        RspReady = 2'b01;
        applyStimulus(0, ADC, 16'h0001, 16'h7FFF, 6'h2A, 1'b0);
        #1 checkOutput("t1 ReqReady", 32'(ReqReady), 32'h1);
        tick();
        ReqValid = 2'b00;
        checkOutput("t1 Busy exec", 32'(Busy), 32'h1);
        checkOutput("t1 AluDest", 32'(AluDest), 32'h7FFF);
        checkOutput("t1 AluSrc", 32'(AluSrc), 32'h0001);
        checkOutput("t1 AluImm", 32'(AluImm), 32'h2A);
        checkOutput("t1 AluOperation", 32'(AluOperation), 32'(ADC));
        checkOutput("t1 RspValid exec", 32'(RspValid), 32'h0);
        tick();
        checkOutput("t1 RspValid", 32'(RspValid), 32'h1);
        checkOutput("t1 RspData", 32'(RspData), 32'h8000);
        checkOutput("t1 RspFlags", 32'(RspFlags), 32'd20);
        tick();
        checkOutput("t1 Busy idle", 32'(Busy), 32'h0);
        checkOutput("t1 RspValid idle", 32'(RspValid), 32'h0);

        // Requester 1 NAND with a stalled response; requester 0 waits meanwhile
        RspReady = 2'b00;
        applyStimulus(1, NAND, 16'hA5A5, 16'h9999, 6'h00, 1'b0);
        #1 checkOutput("t3 ReqReady", 32'(ReqReady), 32'h2);
        tick();
        ReqValid[1] = 1'b0;
        applyStimulus(0, MOVE, 16'h1234, 16'h0000, 6'h00, 1'b0);
        RspReady = 2'b01;
        #1 checkOutput("t3 ReqReady exec", 32'(ReqReady), 32'h0);
        checkOutput("t3 GrantId", 32'(GrantId), 32'h1);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3 hold RspValid", 32'(RspValid), 32'h2);
            checkOutput("t3 hold RspData", 32'(RspData), 32'h7E7E);
            checkOutput("t3 hold ReqReady", 32'(ReqReady), 32'h0);
            tick();
        end
        RspReady = 2'b10;
        tick();
        checkOutput("t3 RspValid after", 32'(RspValid), 32'h0);
        checkOutput("t3 ReqReady after", 32'(ReqReady), 32'h1);
        tick();
        ReqValid = 2'b00;
        RspReady = 2'b01;
        tick();
        checkOutput("t3 req0 RspData", 32'(RspData), 32'h1234);
        checkOutput("t3 req0 GrantId", 32'(GrantId), 32'h0);
        tick();

        // Continuous contention; requester 0 just completed so requester 1 goes first
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        expG = 1'b0;
`else
        expG = 1'b1;
`endif
        applyStimulus(0, MOVE, 16'h1111, 16'h0000, 6'h00, 1'b0);
        applyStimulus(1, MOVE, 16'h2222, 16'h0000, 6'h00, 1'b0);
        RspReady = 2'b11;
        for (int n = 0; n < 4; n++) begin
            #1 checkOutput("t2 ReqReady", 32'(ReqReady), expG ? 32'h2 : 32'h1);
            tick();
            checkOutput("t2 GrantId", 32'(GrantId), 32'(expG));
            checkOutput("t2 ReqReady exec", 32'(ReqReady), 32'h0);
            tick();
            checkOutput("t2 RspValid", 32'(RspValid), expG ? 32'h2 : 32'h1);
            checkOutput("t2 RspData", 32'(RspData), expG ? 32'h2222 : 32'h1111);
            tick();
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            expG = ~expG;
`endif
        end
        ReqValid = 2'b00;

        // Reset in the middle of EXEC drops the transaction
        applyStimulus(0, ADC, 16'h0002, 16'h0001, 6'h00, 1'b1);
        #1 checkOutput("t4 ReqReady", 32'(ReqReady), 32'h1);
        tick();
        ReqValid = 2'b00;
        checkOutput("t4 Busy exec", 32'(Busy), 32'h1);
        #2 nReset = 1'b0;
        #1;
        checkOutput("t4 rst Busy", 32'(Busy), 32'h0);
        checkOutput("t4 rst AluOperation", 32'(AluOperation), 32'(MOVE));
        checkOutput("t4 rst AluSrc", 32'(AluSrc), 32'h0);
        checkOutput("t4 rst AluDest", 32'(AluDest), 32'h0);
        checkOutput("t4 rst RspData", 32'(RspData), 32'h0);
        checkOutput("t4 rst RspValid", 32'(RspValid), 32'h0);
        tick();
        nReset = 1'b1;
        RspReady = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4 no RspValid", 32'(RspValid), 32'h0);
            checkOutput("t4 Busy", 32'(Busy), 32'h0);
        end
        applyStimulus(1, MOVE, 16'h0BEE, 16'h0000, 6'h00, 1'b0);
        #1 checkOutput("t4 req1 ReqReady", 32'(ReqReady), 32'h2);
        tick();
        ReqValid = 2'b00;
        tick();
        checkOutput("t4 req1 RspValid", 32'(RspValid), 32'h2);
        checkOutput("t4 req1 RspData", 32'(RspData), 32'h0BEE);
        tick();

        // SUB from requester 0 while requester 1 keeps changing its payload
        applyStimulus(0, SUB, 16'h00A4, 16'h0000, 6'h00, 1'b1);
        applyStimulus(1, MOVE, 16'h5555, 16'h0000, 6'h00, 1'b0);
        RspReady = 2'b01;
        #1 checkOutput("t5 ReqReady", 32'(ReqReady), 32'h1);
        tick();
        ReqValid[0] = 1'b0;
        ReqSrc[1] = 16'h6666;
        #1 checkOutput("t5 AluSrc a", 32'(AluSrc), 32'h00A4);
        checkOutput("t5 AluOperation", 32'(AluOperation), 32'(SUB));
        #3 ReqSrc[1] = 16'h7777;
        ReqDest[1] = 16'hFFFF;
        #1 checkOutput("t5 AluSrc b", 32'(AluSrc), 32'h00A4);
        tick();
        checkOutput("t5 RspValid", 32'(RspValid), 32'h1);
        checkOutput("t5 RspData", 32'(RspData), 32'hFF5B);
        checkOutput("t5 RspFlags", 32'(RspFlags), 32'h05);
        checkOutput("t5 AluSrc c", 32'(AluSrc), 32'h00A4);
        tick();
        checkOutput("t5 req1 ReqReady", 32'(ReqReady), 32'h2);
        tick();
        ReqValid = 2'b00;
        RspReady = 2'b10;
        tick();
        checkOutput("t5 req1 RspData", 32'(RspData), 32'h7777);
        tick();

        // ReqValid toggling while busy
        RspReady = 2'b00;
        applyStimulus(0, MOVE, 16'h4242, 16'h0000, 6'h00, 1'b0);
        #1 checkOutput("t6 ReqReady idle", 32'(ReqReady), 32'h1);
        tick();
        ReqValid = 2'b11;
        #1 checkOutput("t6 ReqReady exec a", 32'(ReqReady), 32'h0);
        checkOutput("t6 Busy exec", 32'(Busy), 32'h1);
        #2 ReqValid = 2'b00;
        #1 checkOutput("t6 ReqReady exec b", 32'(ReqReady), 32'h0);
        tick();
        ReqValid = 2'b10;
        #1 checkOutput("t6 ReqReady resp", 32'(ReqReady), 32'h0);
        checkOutput("t6 Busy resp", 32'(Busy), 32'h1);
        checkOutput("t6 RspData", 32'(RspData), 32'h4242);
        RspReady = 2'b01;
        tick();
        checkOutput("t6 Busy idle", 32'(Busy), 32'h0);
        checkOutput("t6 ReqReady idle b", 32'(ReqReady), 32'h2);
        ReqValid = 2'b00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
